iir_decim_out: RTL and testbench
================================

IIR_DECIM_OUT -- requirements
Module: iir_decim_out

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the signed input sample width (matches the upstream biquad W).
REQ-002 The block SHALL have parameter OW, default 16, giving the signed output sample width; OW <= W.
REQ-003 The block SHALL have parameter LOG2DEC, default 2, giving the decimation factor DEC = 2**LOG2DEC; LOG2DEC >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: sample strobe, the same strobe that drives the upstream biquad.
REQ-007 The block SHALL have port in, input, W bits, signed: biquad output sample, valid when en=1.
REQ-008 The block SHALL have port out_data, output, OW bits, signed: decimated, saturated sample at the head of the buffer.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid sample.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid and out_ready are both 1.
REQ-011 The block SHALL have port sat, output, 1 bit: sticky flag, set when any output sample was clipped.
REQ-012 The block SHALL have port drop, output, 1 bit: sticky flag, set when any decimated sample was lost on a full buffer.
REQ-013 The block SHALL have port clr_flags, input, 1 bit: a 1 clears sat and drop on the next edge.

Function
REQ-014 The block SHALL accumulate in into a signed accumulator of W+LOG2DEC bits, plus a modulo-DEC counter cnt, only on cycles with en=1; en=0 cycles SHALL leave all accumulation state unchanged.
REQ-015 On an en cycle with cnt = DEC-1, the block SHALL form sum = acc + in, compute avg = sum >>> LOG2DEC (arithmetic shift), clear acc and cnt to 0, and push sat_clip(avg) into the output buffer on the same edge.
REQ-016 sat_clip SHALL clamp avg to [-2**(OW-1), 2**(OW-1)-1]; a clamp SHALL set sat on the same edge.
REQ-017 The output buffer SHALL be a 2-entry FIFO; out_valid SHALL be 1 exactly when the FIFO is non-empty, and out_data SHALL be the head entry.
REQ-018 A pushed sample SHALL appear on out_data with out_valid=1 in the cycle following the pushing edge when the FIFO was empty (1-cycle latency).
REQ-019 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 A push on a full FIFO with a simultaneous pop SHALL be accepted; a push on a full FIFO without a pop SHALL be discarded and SHALL set drop.
REQ-021 A simultaneous push and pop on an empty FIFO SHALL NOT occur, because out_valid=0; a push on a 1-entry FIFO with a pop SHALL leave it at 1 entry holding the new sample.
REQ-022 If clr_flags and a new set condition occur on the same edge, the set condition SHALL win.
REQ-023 out_data SHALL read 0 when the FIFO is empty.

Reset
REQ-024 With rst=1 at an edge, the block SHALL clear acc, cnt, FIFO pointers and count, sat, and drop to 0, giving out_valid=0 and out_data=0.
REQ-025 rst SHALL take priority over en, out_ready and clr_flags; a partial decimation block in progress at reset SHALL be discarded.

Configuration
REQ-026 With the macro IIR_DECIM_ROUND_EN defined, avg SHALL be (sum + 2**(LOG2DEC-1)) >>> LOG2DEC, rounding half up, computed without overflow at W+LOG2DEC+1 bits.
REQ-027 Without IIR_DECIM_ROUND_EN, avg SHALL be sum >>> LOG2DEC, floor truncation; all other behaviour SHALL be identical.

Verification (W=32, OW=16, LOG2DEC=2, out_ready=1 unless stated)
REQ-028 en=1 for 4 cycles with in=1,2,3,4 -> one output: 2 without ROUND_EN, 3 with it; out_valid high for 1 cycle, starting the cycle after the 4th en.
REQ-029 in=-1,-1,-1,-2, with en toggling 1,0,1,0,... -> output -2 (truncate) or -1 (round); en=0 cycles change nothing.
REQ-030 in=40000 x4 -> out_data=32767 and sat=1; then in=-40000 x4 -> -32768; clr_flags pulse -> sat=0.
REQ-031 out_ready=0, 3 full blocks of value 5, 6, 7 -> FIFO holds 5,6; 7 is dropped and drop=1; then out_ready=1 -> outputs 5 then 6 on consecutive cycles.
REQ-032 in=100 x2, then rst=1 for one cycle, then in=8 x4 -> single output 8; no trace of the 100s; flags 0.

Source files
------------

// File: rtl/iir_decim_out.sv
// Decimating output stage for the biquad: block-average DEC samples, saturate to OW bits, 2-entry FIFO.
// Optional macro IIR_DECIM_ROUND_EN selects round-half-up instead of floor truncation.
module iir_decim_out #(
  parameter int W       = 32,
  parameter int OW      = 16,
  parameter int LOG2DEC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [W-1:0]  in,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat,
  output logic                 drop,
  input  logic                 clr_flags
);

  localparam int AW = W + LOG2DEC;
  localparam int SW = AW + 1;

  localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [AW-1:0]      r_acc;
  logic [LOG2DEC-1:0]        r_cnt;
  logic signed [OW-1:0]      r_mem [2];
  logic                      r_wr;
  logic                      r_rd;
  logic [1:0]                r_count;
  logic                      r_sat;
  logic                      r_drop;

  logic signed [SW-1:0]      w_sum;
  logic signed [SW-1:0]      w_avg;
  logic                      w_last;
  logic                      w_push;
  logic                      w_clip_hi;
  logic                      w_clip_lo;
  logic signed [OW-1:0]      w_clipped;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_accept;

  // One extra bit beyond the accumulator keeps the rounding bias from overflowing.
  assign w_sum = SW'(r_acc) + SW'(in);

`ifdef IIR_DECIM_ROUND_EN
  logic signed [SW-1:0] w_biased;
  assign w_biased = w_sum + SW'(2 ** (LOG2DEC - 1));
  assign w_avg    = w_biased >>> LOG2DEC;
`else
  assign w_avg    = w_sum >>> LOG2DEC;
`endif

  assign w_last    = &r_cnt;
  assign w_push    = en & w_last;
  assign w_clip_hi = (w_avg > MAXV);
  assign w_clip_lo = (w_avg < MINV);

  always_comb begin
    w_clipped = w_avg[OW-1:0];
    if (w_clip_hi)      w_clipped = OMAX;
    else if (w_clip_lo) w_clipped = OMIN;
  end

  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == 2'd2);
  assign w_accept  = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
      r_sat   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (en) begin
        if (w_last) r_acc <= '0;
        else        r_acc <= w_sum[AW-1:0];
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_accept) begin
        r_mem[r_wr] <= w_clipped;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // A new set condition overrides a simultaneous clear.
      r_sat  <= (r_sat  & ~clr_flags) | (w_push & (w_clip_hi | w_clip_lo));
      r_drop <= (r_drop & ~clr_flags) | (w_push & w_full & ~w_pop);
    end
  end

  assign out_data = out_valid ? r_mem[r_rd] : '0;
  assign sat      = r_sat;
  assign drop     = r_drop;

endmodule

// File: tb/tb_iir_decim_out.sv
// Self-checking bench for iir_decim_out: queue-based reference model checked every cycle plus literal checkpoints.
module tb_iir_decim_out;

  logic               clk = 1'b0;
  logic               rst, en, out_ready, clr_flags;
  logic signed [31:0] in;
  logic signed [15:0] out_data;
  logic               out_valid, sat, drop;

  int tests = 0;
  int fails = 0;

  iir_decim_out #(.W(32), .OW(16), .LOG2DEC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat(sat), .drop(drop), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  // Reference model: running block sum, sample count, bounded output queue.
  longint m_sum;
  int     m_n;
  int     m_q[$];
  bit     m_sat, m_drop;
  bit     chk_on = 1'b0;

`ifdef IIR_DECIM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  function automatic int avg_clip(input longint s, output bit clipped);
    longint a;
    a = ROUND ? ((s + 2) >>> 2) : (s >>> 2);
    clipped = 1'b0;
    if (a > 32767)       begin a = 32767;  clipped = 1'b1; end
    else if (a < -32768) begin a = -32768; clipped = 1'b1; end
    return int'(a);
  endfunction

  always @(posedge clk) begin
    bit pop, push, clip;
    int v;
    if (rst) begin
      m_sum = 0; m_n = 0; m_q.delete(); m_sat = 0; m_drop = 0;
    end else begin
      pop  = (m_q.size() != 0) && out_ready;
      push = 1'b0;
      clip = 1'b0;
      v    = 0;
      if (clr_flags) begin m_sat = 0; m_drop = 0; end
      if (en) begin
        m_sum += longint'(in);
        m_n++;
        if (m_n == 4) begin
          v = avg_clip(m_sum, clip);
          push = 1'b1;
          m_sum = 0; m_n = 0;
        end
      end
      if (clip) m_sat = 1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 2) m_q.push_back(v);
        else m_drop = 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", longint'(out_valid), longint'(m_q.size() != 0));
      chk("data",  longint'(out_data),  (m_q.size() != 0) ? longint'(m_q[0]) : 0);
      chk("sat",   longint'(sat),       longint'(m_sat));
      chk("drop",  longint'(drop),      longint'(m_drop));
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input int v);
    en = 1'b1; in = v; tick(); en = 1'b0;
  endtask

  task automatic block(input int v);
    for (int i = 0; i < 4; i++) feed(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = '0; out_ready = 1'b1; clr_flags = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data",  longint'(out_data), 0);
    chk("rst_flags", longint'({sat, drop}), 0);
    rst = 1'b0;

    // 1,2,3,4 -> 2 (floor) or 3 (round), valid for one cycle only
    feed(1); feed(2); feed(3); feed(4);
    chk("ramp_valid", longint'(out_valid), 1);
    chk("ramp_data",  longint'(out_data), ROUND ? 3 : 2);
    tick();
    chk("ramp_once", longint'(out_valid), 0);

    // -1,-1,-1,-2 interleaved with idle cycles carrying junk input
    for (int i = 0; i < 4; i++) begin
      feed((i == 3) ? -2 : -1);
      if (i != 3) begin in = 777; tick(); end
    end
    chk("neg_data", longint'(out_data), ROUND ? -1 : -2);
    tick();

    // saturation both ways, then clear
    block(40000);
    chk("sat_hi", longint'(out_data), 32767);
    chk("sat_set", longint'(sat), 1);
    block(-40000);
    chk("sat_lo", longint'(out_data), -32768);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("sat_clr", longint'(sat), 0);

    // backpressure: 5 and 6 buffered, 7 dropped
    out_ready = 1'b0;
    block(5); block(6); block(7);
    chk("bp_drop", longint'(drop), 1);
    chk("bp_head", longint'(out_data), 5);
    out_ready = 1'b1; tick();
    chk("bp_second", longint'(out_data), 6);
    tick();
    chk("bp_empty", longint'(out_valid), 0);

    // clear and a new drop on the same edge: drop stays set
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    out_ready = 1'b0;
    block(1); block(2);
    for (int i = 0; i < 3; i++) feed(3);
    clr_flags = 1'b1; feed(3); clr_flags = 1'b0;
    chk("clr_vs_set", longint'(drop), 1);
    out_ready = 1'b1; tick(); tick();

    // push onto a one-entry FIFO while it pops: new sample becomes head
    out_ready = 1'b0;
    block(9);
    for (int i = 0; i < 3; i++) feed(11);
    out_ready = 1'b1; feed(11);
    chk("push_pop1", longint'(out_data), 11);
    tick();

    // reset mid-block discards partial sum and flags
    feed(100); feed(100);
    rst = 1'b1; en = 1'b1; in = 100; tick(); rst = 1'b0; en = 1'b0;
    block(8);
    chk("rst_mid_data", longint'(out_data), 8);
    chk("rst_mid_flags", longint'({sat, drop}), 0);
    tick();

    // mixed traffic, checked by the per-cycle model
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      in        = $signed($urandom_range(0, 200000)) - 100000;
      out_ready = ($urandom_range(0, 2) != 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
